spi_cs_arbiter: RTL
===================

Name: spi_cs_arbiter

Overview:
Shares one byte-level SPI master among NUM_REQ requesters, each owning one dedicated chip-select line. Round-robin arbitration grants whole multi-byte transactions. The block sequences CS setup, hold and idle gaps, and routes TX/RX bytes between the granted requester and the master byte interface. It sits between the system-side clients and the SPI master, on the same system clock as the slave-side RX/TX handshakes.

Parameters:
NUM_REQ, 4, number of requesters and chip-select lines (2..8)
LEN_W, 4, width of the transaction length field; the maximum transaction is 2^LEN_W-1 bytes
CS_SETUP_CLKS, 2, i_Clk cycles from CS_n falling to the first byte request
CS_HOLD_CLKS, 2, i_Clk cycles from the last RX byte to CS_n rising
CS_IDLE_CLKS, 4, minimum i_Clk cycles with all CS_n high between transactions

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  reset; one clock; reset is asynchronous and active-high
i_Req  in  NUM_REQ  per-requester transaction request, level
i_Req_Len  in  NUM_REQ*LEN_W  packed byte counts; slice k belongs to requester k
i_Req_TX_Byte  in  NUM_REQ*8  packed TX bytes
i_Req_TX_DV  in  NUM_REQ  TX byte valid, one pulse per byte
o_Gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
o_Req_TX_Ready  out  NUM_REQ  granted requester may present the next byte
o_Req_RX_DV  out  NUM_REQ  one-cycle RX byte strobe to the granted requester
o_RX_Byte  out  8  RX byte, shared; valid with o_Req_RX_DV
o_Done  out  NUM_REQ  one-cycle pulse at CS_n rising for the owner
o_M_TX_DV  out  1  byte start strobe to the SPI master
o_M_TX_Byte  out  8  byte to the master
i_M_TX_Ready  in  1  master idle and able to accept a byte
i_M_RX_DV  in  1  master byte complete
i_M_RX_Byte  in  8  byte received by the master
o_SPI_CS_n  out  NUM_REQ  active-low chip selects

Behaviour:
- Reset values: o_SPI_CS_n all 1; every other output 0; state IDLE; RR pointer at NUM_REQ-1 (requester 0 wins first).
- States: IDLE -> SETUP -> WAIT_TX -> WAIT_RX -> (WAIT_TX | HOLD) -> GAP -> IDLE.
- IDLE: if any i_Req is set, pick the first set index searching upward from pointer+1 with wrap-around. Latch its index and length, assert o_Gnt, and drive its CS_n low on the next edge. Update the pointer to the winner.
- Zero length: the grant pulses for one cycle and o_Done pulses; CS_n is never asserted. Go to GAP.
- SETUP: count CS_SETUP_CLKS, then go to WAIT_TX.
- WAIT_TX: o_Req_TX_Ready=1 while i_M_TX_Ready=1. On the owner's i_Req_TX_DV: register the byte to o_M_TX_Byte, pulse o_M_TX_DV for 1 cycle, drop ready, go to WAIT_RX. TX_DV from non-owners is ignored.
- WAIT_RX: on i_M_RX_DV, register i_M_RX_Byte to o_RX_Byte and pulse the owner's o_Req_RX_DV next cycle (1-cycle latency). Decrement the remaining count; nonzero -> WAIT_TX, zero -> HOLD.
- HOLD: count CS_HOLD_CLKS, then raise CS_n, clear o_Gnt, pulse o_Done.
- GAP: count CS_IDLE_CLKS with all CS_n high, then go to IDLE. A request already pending is granted on the first IDLE cycle.
- At most one CS_n is low at any time. Deasserting i_Req mid-transaction has no effect; the transaction runs to its latched length. Requesters must hold i_Req low once o_Done pulses or they are re-queued.
- Counters saturate nowhere. The length counter is LEN_W bits. The delay counters are sized by $clog2 of max(CS_*_CLKS)+1; a delay of 0 means the state lasts one cycle.
- Async reset mid-transaction: CS_n goes high immediately, the master strobe drops, and no o_Done is issued.

Optional Feature:
SPI_ARB_TIMEOUT_EN. When defined, a 16-bit watchdog counts cycles in WAIT_TX and WAIT_RX. It restarts on every state entry, and the limit is the parameter TIMEOUT_CLKS (default 1000). On expiry the block goes to HOLD and pulses the extra output o_Abort[NUM_REQ] for the owner instead of o_Done. Without the macro, the watchdog logic and the o_Abort port and parameter are absent, and the block waits indefinitely.

Decomposition:
- Package spi_arb_pkg: state enum (IDLE, SETUP, WAIT_TX, WAIT_RX, HOLD, GAP) and the state width constant.
- Sub-module rr_arbiter: combinational next-winner search plus the registered pointer, parameterised by NUM_REQ.
- Top level: FSM, counters and muxes.

Test Plan:
- Single requester: req1, len=3, bytes A5/3C/FF, master loops back. Expect CS_n[1] low for the 3 bytes, RX bytes A5/3C/FF to requester 1 only, 2-cycle setup and hold, 1 o_Done[1].
- Fairness: i_Req=4'b1111 held, len=1 each. Grant order 0,1,2,3,0, with at least a 4-cycle all-high gap between CS assertions.
- Simultaneous with a mid-transaction arrival: req0 is in a transaction when req2 and req3 assert. After req0's o_Done, requester 2 is granted before requester 3.
- Zero length: req2 len=0. Expect no CS_n edge, an o_Done[2] pulse, and no master strobe.
- Backpressure: i_M_TX_Ready low for 10 cycles in WAIT_TX. Expect o_Req_TX_Ready low and no o_M_TX_DV until ready returns.
- Reset mid-byte: assert i_Rst in WAIT_RX. Expect CS_n all 1 and o_Gnt 0 within the same cycle, no o_Done, and a fresh request granted to requester 0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI chip-select arbiter: FSM state encoding
// and small constant functions used to size and terminate the delay counters.
package spi_arb_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WAIT_TX = 3'd2,
        WAIT_RX = 3'd3,
        HOLD    = 3'd4,
        GAP     = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Last counter value of a delay state; a zero delay still occupies one cycle.
    function automatic int last_cycle(input int n);
        return (n == 0) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search starting one above the last winner, with the
// registered pointer; requester 0 wins first after reset.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic               i_Update,
    output logic [IDX_W-1:0]   o_Win,
    output logic               o_Found
);

    logic [IDX_W-1:0] r_Ptr;
    logic [IDX_W-1:0] w_Cand;
    logic [IDX_W-1:0] w_Win;
    logic             w_Found;

    // first set request scanning upward from pointer+1 with wrap-around
    always_comb begin
        w_Found = 1'b0;
        w_Win   = '0;
        w_Cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_Cand = IDX_W'((int'(r_Ptr) + i) % NUM_REQ);
            if (!w_Found && i_Req[w_Cand]) begin
                w_Found = 1'b1;
                w_Win   = w_Cand;
            end else begin
                w_Found = w_Found;
            end
        end
    end

    // pointer follows the most recent winner
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Ptr <= IDX_W'(NUM_REQ - 1);
        end else if (i_Update) begin
            r_Ptr <= w_Win;
        end else begin
            r_Ptr <= r_Ptr;
        end
    end

    assign o_Win   = w_Win;
    assign o_Found = w_Found;

endmodule

// File: rtl/spi_cs_arbiter.sv
// Shares one byte-level SPI master among NUM_REQ chip-select owners with
// round-robin transaction grants. Optional watchdog: SPI_ARB_TIMEOUT_EN.
module spi_cs_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int LEN_W         = 4,
    parameter int CS_SETUP_CLKS = 2,
    parameter int CS_HOLD_CLKS  = 2,
    parameter int CS_IDLE_CLKS  = 4
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CLKS  = 1000
`endif
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic [NUM_REQ-1:0]       i_Req,
    input  logic [NUM_REQ*LEN_W-1:0] i_Req_Len,
    input  logic [NUM_REQ*8-1:0]     i_Req_TX_Byte,
    input  logic [NUM_REQ-1:0]       i_Req_TX_DV,
    output logic [NUM_REQ-1:0]       o_Gnt,
    output logic [NUM_REQ-1:0]       o_Req_TX_Ready,
    output logic [NUM_REQ-1:0]       o_Req_RX_DV,
    output logic [7:0]               o_RX_Byte,
    output logic [NUM_REQ-1:0]       o_Done,
    output logic                     o_M_TX_DV,
    output logic [7:0]               o_M_TX_Byte,
    input  logic                     i_M_TX_Ready,
    input  logic                     i_M_RX_DV,
    input  logic [7:0]               i_M_RX_Byte,
`ifdef SPI_ARB_TIMEOUT_EN
    output logic [NUM_REQ-1:0]       o_Abort,
`endif
    output logic [NUM_REQ-1:0]       o_SPI_CS_n
);

    localparam int IDX_W      = $clog2(NUM_REQ);
    localparam int BYTE_W     = 8;
    localparam int DLY_MAX    = max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS);
    localparam int CNT_W      = (DLY_MAX < 1) ? 1 : $clog2(DLY_MAX + 1);
    localparam int SETUP_LAST = last_cycle(CS_SETUP_CLKS);
    localparam int HOLD_LAST  = last_cycle(CS_HOLD_CLKS);
    localparam int GAP_LAST   = last_cycle(CS_IDLE_CLKS);

    state_t               r_State;
    logic [IDX_W-1:0]     r_Owner;
    logic [LEN_W-1:0]     r_Len;
    logic [CNT_W-1:0]     r_Cnt;
    logic [NUM_REQ-1:0]   r_Gnt;
    logic [NUM_REQ-1:0]   r_CS_n;
    logic [NUM_REQ-1:0]   r_RX_DV;
    logic [NUM_REQ-1:0]   r_Done;
    logic [7:0]           r_RX_Byte;
    logic [7:0]           r_M_TX_Byte;
    logic                 r_M_TX_DV;
    logic [IDX_W-1:0]     w_Win;
    logic                 w_Found;
    logic [LEN_W-1:0]     w_Win_Len;
    logic [NUM_REQ-1:0]   w_Win_Oh;
    logic [NUM_REQ-1:0]   w_Owner_Oh;
    logic                 w_TX_Accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Req    (i_Req),
        .i_Update (r_State == IDLE && w_Found),
        .o_Win    (w_Win),
        .o_Found  (w_Found)
    );

    assign w_Win_Len   = i_Req_Len[w_Win*LEN_W +: LEN_W];
    assign w_Win_Oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_Win;
    assign w_Owner_Oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_Owner;
    assign w_TX_Accept = i_M_TX_Ready && i_Req_TX_DV[r_Owner];

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0]        r_Wd;
    state_t             r_Prev_State;
    logic               r_Abort_Pend;
    logic [NUM_REQ-1:0] r_Abort;
    logic               w_Expired;

    // watchdog restarts on every state entry and only runs while waiting on bytes
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Wd         <= 16'd0;
            r_Prev_State <= IDLE;
        end else begin
            r_Prev_State <= r_State;
            if (r_State != r_Prev_State) begin
                r_Wd <= 16'd0;
            end else if (r_State == WAIT_TX || r_State == WAIT_RX) begin
                r_Wd <= r_Wd + 16'd1;
            end else begin
                r_Wd <= r_Wd;
            end
        end
    end

    assign w_Expired = (r_State == WAIT_TX || r_State == WAIT_RX) &&
                       (r_State == r_Prev_State) && (r_Wd >= 16'(TIMEOUT_CLKS - 1));
    assign o_Abort   = r_Abort;
`endif

    // transaction sequencer; strobes default low and are raised for one cycle
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State     <= IDLE;
            r_Owner     <= '0;
            r_Len       <= '0;
            r_Cnt       <= '0;
            r_Gnt       <= '0;
            r_CS_n      <= '1;
            r_RX_DV     <= '0;
            r_Done      <= '0;
            r_RX_Byte   <= 8'h00;
            r_M_TX_Byte <= 8'h00;
            r_M_TX_DV   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_Abort_Pend <= 1'b0;
            r_Abort      <= '0;
`endif
        end else begin
            r_M_TX_DV <= 1'b0;
            r_RX_DV   <= '0;
            r_Done    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_Abort   <= '0;
`endif
            case (r_State)
                IDLE: begin
                    r_Cnt <= '0;
                    if (w_Found) begin
                        r_Owner <= w_Win;
                        r_Len   <= w_Win_Len;
                        r_Gnt   <= w_Win_Oh;
`ifdef SPI_ARB_TIMEOUT_EN
                        r_Abort_Pend <= 1'b0;
`endif
                        // empty transaction: grant and done pulse together, CS untouched
                        if (w_Win_Len == '0) begin
                            r_Done  <= w_Win_Oh;
                            r_State <= GAP;
                        end else begin
                            r_CS_n  <= ~w_Win_Oh;
                            r_State <= SETUP;
                        end
                    end else begin
                        r_Gnt <= '0;
                    end
                end
                SETUP: begin
                    if (r_Cnt == CNT_W'(SETUP_LAST)) begin
                        r_State <= WAIT_TX;
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                end
                WAIT_TX: begin
                    if (w_TX_Accept) begin
                        r_M_TX_Byte <= i_Req_TX_Byte[r_Owner*BYTE_W +: BYTE_W];
                        r_M_TX_DV   <= 1'b1;
                        r_State     <= WAIT_RX;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (w_Expired) begin
                        r_Abort_Pend <= 1'b1;
                        r_Cnt        <= '0;
                        r_State      <= HOLD;
                    end
`endif
                    else begin
                        r_State <= WAIT_TX;
                    end
                end
                WAIT_RX: begin
                    if (i_M_RX_DV) begin
                        r_RX_Byte <= i_M_RX_Byte;
                        r_RX_DV   <= w_Owner_Oh;
                        r_Len     <= r_Len - LEN_W'(1);
                        r_Cnt     <= '0;
                        if (r_Len == LEN_W'(1)) begin
                            r_State <= HOLD;
                        end else begin
                            r_State <= WAIT_TX;
                        end
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (w_Expired) begin
                        r_Abort_Pend <= 1'b1;
                        r_Cnt        <= '0;
                        r_State      <= HOLD;
                    end
`endif
                    else begin
                        r_State <= WAIT_RX;
                    end
                end
                HOLD: begin
                    if (r_Cnt == CNT_W'(HOLD_LAST)) begin
                        r_CS_n  <= '1;
                        r_Gnt   <= '0;
                        r_Cnt   <= '0;
                        r_State <= GAP;
`ifdef SPI_ARB_TIMEOUT_EN
                        if (r_Abort_Pend) begin
                            r_Abort <= w_Owner_Oh;
                        end else begin
                            r_Done  <= w_Owner_Oh;
                        end
`else
                        r_Done <= w_Owner_Oh;
`endif
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                end
                GAP: begin
                    r_Gnt <= '0;
                    if (r_Cnt == CNT_W'(GAP_LAST)) begin
                        r_Cnt   <= '0;
                        r_State <= IDLE;
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                end
                default: begin
                    r_State <= IDLE;
                    r_CS_n  <= '1;
                    r_Gnt   <= '0;
                    r_Cnt   <= '0;
                end
            endcase
        end
    end

    // ready follows the master live so a byte is never offered to a busy master
    assign o_Req_TX_Ready = (r_State == WAIT_TX && i_M_TX_Ready) ? w_Owner_Oh : '0;
    assign o_Gnt          = r_Gnt;
    assign o_Req_RX_DV    = r_RX_DV;
    assign o_RX_Byte      = r_RX_Byte;
    assign o_Done         = r_Done;
    assign o_M_TX_DV      = r_M_TX_DV;
    assign o_M_TX_Byte    = r_M_TX_Byte;
    assign o_SPI_CS_n     = r_CS_n;

endmodule
